// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed scan controller for common-anode 7-seg digits.
// One shared decoder, blank gap per slot, frame-aligned shadow updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [3:0]              nibble,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_n;
  logic [VW-1:0]       shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [VW-1:0]       active;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [VW-1:0]       active_nx;
  logic [NUM_DIGITS-1:0] active_dp_nx;
  logic                lz_q;
  logic                last;
  logic                boundary_n;
  logic                show_entry;
  logic                blank_n;
  logic [NUM_DIGITS-1:0] en_n;

  // True when every nibble and dp bit from digit k upward is zero.
  function automatic logic upper_zero(
    input logic [VW-1:0]         v,
    input logic [NUM_DIGITS-1:0] d,
    input logic [IW-1:0]         k
  );
    logic z;
    z = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(k)) begin
        if (v[4*i +: 4] != 4'h0 || d[i]) z = 1'b0;
      end
    end
    return z;
  endfunction

  always_comb begin
    last    = (cnt == CW'(SLOT_CYC - 1));
    cnt_n   = last ? '0 : cnt + 1'b1;
    idx_n   = idx;
    if (last) begin
      idx_n = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    state_n = (cnt_n < CW'(BLANK_CYC)) ? BLANK : SHOW;
    show_entry = (state == BLANK) && (state_n == SHOW);
    boundary_n = last && (idx == IW'(NUM_DIGITS - 1));
  end

  // Active only moves at the end of the frame-start cycle.
  always_comb begin
    active_nx    = active;
    active_dp_nx = active_dp;
    if (frame_start) begin
      if (load) begin
        active_nx    = value_in;
        active_dp_nx = dp_in;
      end else if (pending) begin
        active_nx    = shadow;
        active_dp_nx = shadow_dp;
      end
    end
  end

  always_comb begin
    blank_n = lz_q && (idx_n != '0) &&
              upper_zero(active_nx, active_dp_nx, idx_n);
    en_n        = '1;
    en_n[idx_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      active      <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
      lz_q        <= 1'b0;
      nibble      <= 4'h0;
      dp_out      <= 1'b0;
      digit_en_n  <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      frame_start <= boundary_n;
      active      <= active_nx;
      active_dp   <= active_dp_nx;
      if (frame_start) begin
        pending <= 1'b0;
      end else if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end
      if (cnt_n == '0) lz_q <= lz_en;
      // Nibble settles during the gap; enable follows at show entry.
      if (state_n == BLANK) begin
        nibble     <= active_nx[4*idx_n +: 4];
        digit_en_n <= '1;
        dp_out     <= 1'b0;
      end else if (show_entry) begin
        nibble     <= active_nx[4*idx_n +: 4];
        digit_en_n <= blank_n ? '1 : en_n;
        dp_out     <= active_dp_nx[idx_n];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + random stimulus against a
// position-based reference model of the scan sequence.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  nibble;
  logic        dp_out;
  logic [3:0]  digit_en_n;
  logic        frame_start;
  logic        pending;

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .SLOT_CYC(8),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value_in(value_in),
    .dp_in(dp_in),
    .load(load),
    .lz_en(lz_en),
    .nibble(nibble),
    .dp_out(dp_out),
    .digit_en_n(digit_en_n),
    .frame_start(frame_start),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: t = cycles since reset release.
  int          t;
  logic [15:0] m_act;
  logic [3:0]  m_dp;
  logic [15:0] m_sh;
  logic [3:0]  m_shdp;
  logic        m_pend;
  logic        m_lz;
  logic [3:0]  prev_en;
  logic [3:0]  prev_nib;
  logic        watch_1111;
  logic        saw_1111;
  logic        lzr;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %h expected %h",
             tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_act = '0;
    m_dp = '0;
    m_sh = '0;
    m_shdp = '0;
    m_pend = 1'b0;
    m_lz = 1'b0;
    prev_en = 4'hF;
    prev_nib = 4'h0;
  endtask

  task automatic check_outputs();
    int pos, id, c;
    logic blk;
    logic [3:0] e_en;
    logic [3:0] e_nib;
    logic e_dp;
    pos = t % 32;
    id = pos / 8;
    c = pos % 8;
    e_nib = 4'((m_act >> (4 * id)) & 16'hF);
    blk = m_lz && id > 0 &&
          (m_act >> (4 * id)) == 16'h0 &&
          (m_dp >> id) == 4'h0;
    e_en = (c < 2 || blk) ? 4'hF : ~(4'b1 << id);
    e_dp = (c >= 2) ? m_dp[id] : 1'b0;
    chk("digit_en_n", 16'(digit_en_n), 16'(e_en));
    chk("nibble", 16'(nibble), 16'(e_nib));
    chk("dp_out", 16'(dp_out), 16'(e_dp));
    chk("frame_start", 16'(frame_start),
        16'(pos == 0 && t > 0));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("one_low", 16'($countones(~digit_en_n) <= 1), 16'h1);
    if (prev_en != 4'hF && digit_en_n != 4'hF)
      chk("nib_stable", 16'(nibble), 16'(prev_nib));
    if (watch_1111 && digit_en_n != 4'hF && nibble == 4'h1)
      saw_1111 = 1'b1;
    prev_en = digit_en_n;
    prev_nib = nibble;
  endtask

  task automatic advance(input logic ld, input logic [15:0] v,
                         input logic [3:0] d, input logic lz);
    if (t % 32 == 0 && t > 0) begin
      if (ld) begin
        m_act = v;
        m_dp = d;
      end else if (m_pend) begin
        m_act = m_sh;
        m_dp = m_shdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh = v;
      m_shdp = d;
      m_pend = 1'b1;
    end
    t++;
    if (t % 8 == 0) m_lz = lz;
  endtask

  task automatic step(input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic lz);
    load = ld;
    value_in = v;
    dp_in = d;
    lz_en = lz;
    @(posedge clk);
    advance(ld, v, d, lz);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    watch_1111 = 1'b0;
    saw_1111 = 1'b0;
    lzr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Idle scan, two frames
    repeat (64) step(1'b0, 16'h0, 4'h0, 1'b0);

    // Mid-frame load, dp on digit 2
    repeat (10) step(1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 16'h1A3F, 4'b0100, 1'b0);
    repeat (60) step(1'b0, 16'h0, 4'h0, 1'b0);

    // Leading-zero blanking
    step(1'b1, 16'h0005, 4'h0, 1'b1);
    repeat (70) step(1'b0, 16'h0, 4'h0, 1'b1);

    // Two loads, then a load on the boundary cycle
    while (t % 32 != 5) step(1'b0, 16'h0, 4'h0, 1'b1);
    watch_1111 = 1'b1;
    step(1'b1, 16'h1111, 4'h0, 1'b1);
    repeat (10) step(1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b1, 16'h2222, 4'h0, 1'b1);
    while (t % 32 != 0) step(1'b0, 16'h0, 4'h0, 1'b1);
    chk("fs_before_3333", 16'(frame_start), 16'h1);
    step(1'b1, 16'h3333, 4'h0, 1'b1);
    chk("pend_after_3333", 16'(pending), 16'h0);
    repeat (40) step(1'b0, 16'h0, 4'h0, 1'b1);
    watch_1111 = 1'b0;
    chk("never_1111", 16'(saw_1111), 16'h0);

    // Reset during digit-2 SHOW with a pending value
    while (t % 32 != 17) step(1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 16'hBEEF, 4'b1000, 1'b0);
    while (t % 32 != 20) step(1'b0, 16'h0, 4'h0, 1'b0);
    chk("pre_rst_pend", 16'(pending), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_en", 16'(digit_en_n), 16'hF);
    chk("rst_nib", 16'(nibble), 16'h0);
    chk("rst_pend", 16'(pending), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    repeat (70) step(1'b0, 16'h0, 4'h0, 1'b0);

    // Random loads and lz toggling
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) lzr = ~lzr;
      step($urandom_range(0, 7) == 0, 16'($urandom),
           4'($urandom), lzr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
